ps2_key_fifo: RTL

Memory-mapped PS/2 keyboard controller with a parametrised scan-code FIFO, replacing the single-byte keyboard write port into data memory. It deserialises PS/2 frames, resolves E0/F0 prefixes into one tagged entry per key event, and buffers entries so the CPU can drain them by polling or on `irq`. It sits on the CPU data bus alongside data memory, decoded at `BASE_ADDR`.

---
 rtl/ps2_key_fifo.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_fifo
// Purpose  : Memory-mapped PS/2 keyboard controller. Deserialises PS/2 frames,
//            folds E0/F0 prefixes into one tagged entry {ext, brk, code} per
//            key event and buffers entries in a FIFO that the CPU drains by
//            polling the DATA register or on irq.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock (only clock)
//   rst        in   1  asynchronous active-low reset
//   ps2_clk    in   1  PS/2 clock, asynchronous to clk
//   ps2_data   in   1  PS/2 data, asynchronous to clk
//   addr       in  32  CPU byte address
//   rd_en      in   1  CPU read strobe; a DATA read pops the FIFO
//   we         in   1  CPU write strobe
//   wd         in  32  CPU write data
//   rd         out 32  read data, combinational from addr
//   key_valid  out  1  one-cycle pulse per entry pushed
//   irq        out  1  high while the FIFO holds entries
// Registers
//   BASE_ADDR    DATA   : read {22'b0, ext, brk, code} of head (0 if empty);
//                         write wd[0]=1 flushes the FIFO
//   BASE_ADDR+4  STATUS : {16'b0, count[7:0], 4'b0, ERR, OVF, full, empty};
//                         write wd[2]=1 clears OVF, wd[3]=1 clears ERR
// ============================================================================
module ps2_key_fifo #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'd40,
  parameter int          TIMEOUT    = 50000,
  parameter bit          KEEP_BREAK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        key_valid,
  output logic        irq
);

  localparam int          PW           = $clog2(DEPTH);
  localparam int          CW           = PW + 1;
  localparam int          TW           = $clog2(TIMEOUT + 1);
  localparam logic [31:0] STATUS_ADDR  = BASE_ADDR + 32'd4;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers and falling-edge detect. Flops reset to 1 (idle bus)
  // so that reset release can never look like a falling edge.
  // --------------------------------------------------------------------------
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // --------------------------------------------------------------------------
  // Frame receiver
  // --------------------------------------------------------------------------
  rx_state_t     state, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_stb;
  logic          frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= state_d;
      // Inactivity counter only runs inside a frame and restarts on every edge.
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= 3'd0;
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= data_s2;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d   = state;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE:   if (fall && !data_s2)        state_d = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_d = PARITY;
      PARITY: if (fall)                    state_d = STOP;
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          // Data plus parity must carry an odd number of ones.
          if (data_s2 && (^{shift, par_bit})) byte_stb  = 1'b1;
          else                                frame_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state != IDLE && !fall && tcnt == TIMEOUT_LAST) state_d = IDLE;
  end

  // --------------------------------------------------------------------------
  // Prefix decoder: E0/F0 only arm flags; any other byte emits one entry.
  // --------------------------------------------------------------------------
  logic       ext, brk;
  logic       is_prefix;
  logic       push_req;
  logic [9:0] entry;

  assign is_prefix = (shift == 8'hE0) || (shift == 8'hF0);
  assign entry     = {ext, brk, shift};
  assign push_req  = byte_stb && !is_prefix && (KEEP_BREAK || !brk);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_stb) begin
      if (shift == 8'hE0)      ext <= 1'b1;
      else if (shift == 8'hF0) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO and CPU register interface
  // --------------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          data_sel, stat_sel;
  logic          pop, push, flush, ovf_set;
  logic          ovf, err;
  logic          unused_wd;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign data_sel = (addr == BASE_ADDR);
  assign stat_sel = (addr == STATUS_ADDR);
  assign pop      = rd_en && data_sel && !empty;
  assign flush    = we && data_sel && wd[0];
  // The pop frees a slot before the push lands, so push+pop on full succeeds.
  assign push     = push_req && !flush && (!full || pop);
  assign ovf_set  = push_req && !flush && full && !pop;
  assign unused_wd = ^{wd[31:4], wd[1]};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= push;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // A set in the same cycle as a W1C clear wins.
      ovf <= ovf_set   | (ovf & ~(we && stat_sel && wd[2]));
      err <= frame_err | (err & ~(we && stat_sel && wd[3]));
    end
  end

  assign irq = !empty;

  always_comb begin
    rd = 32'd0;
    if (data_sel) begin
      if (!empty) rd = {22'd0, mem[rptr]};
    end else if (stat_sel) begin
      rd = {16'd0, 8'(count), 4'd0, err, ovf, full, empty};
    end
  end

endmodule
`default_nettype wire
